// File: rtl/data_mem_lsu.sv
// Load/store initiator for a single-port byte-enabled data RAM: lane alignment,
// sign/zero extension, and splitting of word-crossing accesses into two RAM cycles.
module data_mem_lsu #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [2:0]            op_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE1 = 3'd1,
        S_ISSUE2 = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    function automatic logic [3:0] size_mask(input logic [2:0] op);
        case (op[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    // Loads accept B/H/W/BU/HU; stores only B/H/W.
    function automatic logic op_illegal(input logic we, input logic [2:0] op);
        op_illegal = (op == 3'b011) || (op[2:1] == 2'b11) || (we && op[2]);
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] op);
        case (op)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b010:  extend = d;
            3'b100:  extend = {24'h000000, d[7:0]};
            3'b101:  extend = {16'h0000, d[15:0]};
            default: extend = 32'h0000_0000;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic                    gnt_q, gnt_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ram_en_q, ram_en_d;
    logic                    ram_we_q, ram_we_d;
    logic [3:0]              ram_be_q, ram_be_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic                    we_q, we_d;
    logic [2:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    split_q, split_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;

    logic [2:0]              cur_op_s;
    logic [ADDR_WIDTH-1:0]   cur_addr_s;
    logic [DATA_WIDTH-1:0]   cur_wdata_s;
    logic [1:0]              off_s;
    logic [7:0]              be8_s;
    logic [2*DATA_WIDTH-1:0] wd64_s;
    logic                    split_s;
    logic [2*DATA_WIDTH-1:0] rd64_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;

    // Lane math works on the live request in IDLE and on the captured one afterwards.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_op_s    = op_i;
            cur_addr_s  = addr_i;
            cur_wdata_s = wdata_i;
        end else begin
            cur_op_s    = op_q;
            cur_addr_s  = addr_q;
            cur_wdata_s = wdata_q;
        end
        off_s   = cur_addr_s[1:0];
        be8_s   = {4'b0000, size_mask(cur_op_s)} << off_s;
        wd64_s  = {{DATA_WIDTH{1'b0}}, cur_wdata_s} << {off_s, 3'b000};
        split_s = |be8_s[7:4];
    end

    // Read-data assembly: split loads combine the captured low word with the live high word.
    always_comb begin
        if (split_q) begin
            rd64_s = {ram_rdata_i, lo_q};
        end else begin
            rd64_s = {{DATA_WIDTH{1'b0}}, ram_rdata_i};
        end
        rd_word_s = rd64_s[DATA_WIDTH-1:0] >> {addr_q[1:0], 3'b000};
        rd_word_s = rd_word_s | (rd64_s[2*DATA_WIDTH-1:DATA_WIDTH] << (6'd32 - {1'b0, addr_q[1:0], 3'b000}));
        if (addr_q[1:0] == 2'b00) begin
            rd_word_s = rd64_s[DATA_WIDTH-1:0];
        end else begin
            rd_word_s = rd_word_s;
        end
    end

    // Next-state and next-output logic; RAM pins and response are loaded with the state.
    always_comb begin
        state_d      = state_q;
        gnt_d        = 1'b0;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        rdata_d      = {DATA_WIDTH{1'b0}};
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_be_d     = 4'b0000;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = {DATA_WIDTH{1'b0}};
        we_d         = we_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        split_d      = split_q;
        lo_d         = lo_q;
        case (state_q)
            S_IDLE: begin
                if (req_i && gnt_q) begin
                    we_d    = we_i;
                    op_d    = op_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    split_d = split_s;
                    if (op_illegal(we_i, op_i) || (split_s && (MISALIGN_SPLIT == 0))) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                    end else begin
                        state_d     = S_ISSUE1;
                        ram_en_d    = 1'b1;
                        ram_we_d    = we_i;
                        ram_addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        ram_be_d    = be8_s[3:0];
                        ram_wdata_d = wd64_s[DATA_WIDTH-1:0];
                    end
                end else begin
                    gnt_d = 1'b1;
                end
            end
            S_ISSUE1: begin
                if (split_q) begin
                    state_d     = S_ISSUE2;
                    ram_en_d    = 1'b1;
                    ram_we_d    = we_q;
                    ram_addr_d  = ram_addr_q + ADDR_WIDTH'(4);
                    ram_be_d    = be8_s[7:4];
                    ram_wdata_d = wd64_s[2*DATA_WIDTH-1:DATA_WIDTH];
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ISSUE2: begin
                lo_d    = ram_rdata_i;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                if (we_q) begin
                    rdata_d = {DATA_WIDTH{1'b0}};
                end else begin
                    rdata_d = extend(rd_word_s, op_q);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                gnt_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 1'b1;
            end
        endcase
    end

    // State, request capture and registered outputs.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            gnt_q        <= 1'b1;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= {DATA_WIDTH{1'b0}};
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_be_q     <= 4'b0000;
            ram_addr_q   <= {ADDR_WIDTH{1'b0}};
            ram_wdata_q  <= {DATA_WIDTH{1'b0}};
            we_q         <= 1'b0;
            op_q         <= 3'b000;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            wdata_q      <= {DATA_WIDTH{1'b0}};
            split_q      <= 1'b0;
            lo_q         <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_be_q     <= ram_be_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            we_q         <= we_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            split_q      <= split_d;
            lo_q         <= lo_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign resp_valid_o = resp_valid_q;
    assign err_o        = err_q;
    assign rdata_o      = rdata_q;
    assign ram_en_o     = ram_en_q;
    assign ram_we_o     = ram_we_q;
    assign ram_be_o     = ram_be_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized + directed bench for data_mem_lsu against a byte-level memory reference model.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_i = 1'b0;
    logic        req2_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic [7:0]  addr_i = 8'h00;
    logic [31:0] wdata_i = 32'h0;
    logic        gnt_o, resp_valid_o, err_o, ram_en_o, ram_we_o;
    logic [31:0] rdata_o, ram_wdata_o;
    logic [7:0]  ram_addr_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_rdata = 32'h0;
    logic        gnt2, resp2, err2, ram_en2, ram_we2;
    logic [31:0] rdata2, ram_wdata2;
    logic [7:0]  ram_addr2;
    logic [3:0]  ram_be2;

    logic [7:0]  mem [0:255];
    logic [7:0]  ref_mem [0:255];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_mem_lsu #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MISALIGN_SPLIT(1)) dut (
        .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
        .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .resp_valid_o(resp_valid_o),
        .rdata_o(rdata_o), .err_o(err_o), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_rdata_i(ram_rdata)
    );

    data_mem_lsu #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MISALIGN_SPLIT(0)) dut2 (
        .clk(clk), .rstn_i(rstn_i), .req_i(req2_i), .gnt_o(gnt2), .we_i(we_i),
        .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .resp_valid_o(resp2),
        .rdata_o(rdata2), .err_o(err2), .ram_en_o(ram_en2), .ram_addr_o(ram_addr2),
        .ram_wdata_o(ram_wdata2), .ram_we_o(ram_we2), .ram_be_o(ram_be2),
        .ram_rdata_i(32'h0)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
    end

    // Byte-enabled synchronous RAM, read data one cycle after en.
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[8'(ram_addr_o + 8'(b))] <= ram_wdata_o[8*b +: 8];
            end else begin
                ram_rdata <= {mem[8'(ram_addr_o + 8'd3)], mem[8'(ram_addr_o + 8'd2)],
                              mem[8'(ram_addr_o + 8'd1)], mem[ram_addr_o]};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic w, input logic [2:0] op, input logic [7:0] a, input logic [31:0] wd);
        int          n, lat, n_acc, exp_n, exp_lat;
        logic        legal, exp_err, got, split;
        logic [3:0]  be1, be2;
        logic [31:0] wd1, wd2, exp_val, got_rd, m1, m2;
        logic        got_err;
        logic [7:0]  ba;
        logic [7:0]  acc_addr [2];
        logic [3:0]  acc_be [2];
        logic        acc_we [2];
        logic [31:0] acc_wd [2];

        legal = (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5) && !(w && op[2]);
        n = (op[1:0] == 2'd0) ? 1 : ((op[1:0] == 2'd1) ? 2 : 4);
        be1 = 4'h0; be2 = 4'h0; wd1 = 32'h0; wd2 = 32'h0; exp_val = 32'h0;
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                ba = 8'(a + 8'(i));
                if ((ba & 8'hFC) == (a & 8'hFC)) begin
                    be1[ba[1:0]] = 1'b1;
                    wd1[8*ba[1:0] +: 8] = wd[8*i +: 8];
                end else begin
                    be2[ba[1:0]] = 1'b1;
                    wd2[8*ba[1:0] +: 8] = wd[8*i +: 8];
                end
                if (!w) exp_val[8*i +: 8] = ref_mem[ba];
            end
            if (!w && !op[2] && n < 4 && exp_val[8*n-1]) begin
                for (int i = 8*n; i < 32; i++) exp_val[i] = 1'b1;
            end
            if (w) exp_val = 32'h0;
        end
        split   = (be2 != 4'h0);
        exp_err = !legal;
        exp_n   = exp_err ? 0 : (split ? 2 : 1);
        exp_lat = exp_err ? 1 : (split ? 4 : 3);

        @(negedge clk);
        chk("gnt_idle", 32'(gnt_o), 32'd1);
        req_i = 1'b1; we_i = w; op_i = op; addr_i = a; wdata_i = wd;
        @(posedge clk);
        lat = 0; n_acc = 0; got = 1'b0; got_rd = 32'h0; got_err = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            req_i = 1'b0;
            lat++;
            if (ram_en_o && n_acc < 2) begin
                acc_addr[n_acc] = ram_addr_o; acc_be[n_acc] = ram_be_o;
                acc_we[n_acc] = ram_we_o; acc_wd[n_acc] = ram_wdata_o;
                n_acc++;
            end
            if (resp_valid_o) begin
                got = 1'b1; got_rd = rdata_o; got_err = err_o;
            end
        end
        chk("resp_seen", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", 32'(got_err), 32'(exp_err));
        chk("rdata", got_rd, exp_val);
        chk("ram_accesses", 32'(n_acc), 32'(exp_n));
        for (int k = 0; k < n_acc && k < exp_n; k++) begin
            chk("acc_addr", 32'(acc_addr[k]), (k == 0) ? 32'(a & 8'hFC) : 32'(8'((a & 8'hFC) + 8'd4)));
            chk("acc_be", 32'(acc_be[k]), (k == 0) ? 32'(be1) : 32'(be2));
            chk("acc_we", 32'(acc_we[k]), 32'(w));
            if (w) begin
                m1 = {{8{acc_be[k][3]}}, {8{acc_be[k][2]}}, {8{acc_be[k][1]}}, {8{acc_be[k][0]}}};
                m2 = (k == 0) ? wd1 : wd2;
                chk("acc_wdata", acc_wd[k] & m1, m2);
            end
        end
        @(negedge clk);
        chk("resp_pulse_low", 32'(resp_valid_o), 32'd0);
        if (w && legal) begin
            for (int i = 0; i < n; i++) ref_mem[8'(a + 8'(i))] = wd[8*i +: 8];
        end
    endtask

    initial begin
        logic        seen;
        logic        w;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [2:0]  ld_ops [5];
        ld_ops[0] = 3'd0; ld_ops[1] = 3'd1; ld_ops[2] = 3'd2; ld_ops[3] = 3'd4; ld_ops[4] = 3'd5;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);

        // Reset state
        repeat (3) @(negedge clk);
        rstn_i = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 32'd1);
        chk("rst_ram_en", 32'(ram_en_o), 32'd0);
        chk("rst_resp", 32'(resp_valid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_be", 32'(ram_be_o), 32'd0);

        // Directed plan items
        do_op(1'b1, 3'd2, 8'h10, 32'hDEADBEEF);
        do_op(1'b0, 3'd2, 8'h10, 32'h0);
        do_op(1'b1, 3'd0, 8'h13, 32'h00000080);
        do_op(1'b0, 3'd0, 8'h13, 32'h0);
        do_op(1'b0, 3'd4, 8'h13, 32'h0);
        do_op(1'b1, 3'd2, 8'h0E, 32'h11223344);
        do_op(1'b0, 3'd2, 8'h0E, 32'h0);
        do_op(1'b0, 3'd5, 8'h0F, 32'h0);
        do_op(1'b0, 3'd0, 8'h0D, 32'h0);
        do_op(1'b0, 3'd0, 8'h12, 32'h0);
        do_op(1'b0, 3'd1, 8'hFF, 32'h0);
        do_op(1'b0, 3'd3, 8'h20, 32'h0);
        do_op(1'b0, 3'd6, 8'h20, 32'h0);
        do_op(1'b1, 3'd4, 8'h20, 32'h12345678);
        do_op(1'b1, 3'd1, 8'hFF, 32'hCAFEA55A);
        do_op(1'b0, 3'd1, 8'hFF, 32'h0);

        // Misaligned word with splitting disabled
        @(negedge clk);
        req2_i = 1'b1; we_i = 1'b0; op_i = 3'd2; addr_i = 8'h02;
        @(posedge clk);
        @(negedge clk);
        req2_i = 1'b0;
        chk("nosplit_resp", 32'(resp2), 32'd1);
        chk("nosplit_err", 32'(err2), 32'd1);
        chk("nosplit_ram_en", 32'(ram_en2), 32'd0);
        @(negedge clk);
        chk("nosplit_ram_en_after", 32'(ram_en2), 32'd0);

        // Asynchronous reset during ISSUE1 drops the request
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; op_i = 3'd2; addr_i = 8'h20;
        @(posedge clk);
        #1;
        chk("issue1_en", 32'(ram_en_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        chk("async_rst_en", 32'(ram_en_o), 32'd0);
        chk("async_rst_gnt", 32'(gnt_o), 32'd1);
        @(negedge clk);
        req_i = 1'b0;
        rstn_i = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid_o || ram_en_o) seen = 1'b1;
        end
        chk("no_resp_after_rst", 32'(seen), 32'd0);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) < 2) op = 3'($urandom_range(0, 7));
            else if (w) op = 3'($urandom_range(0, 2));
            else op = ld_ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 1) == 1) a = 8'($urandom_range(0, 255));
            else a = 8'($urandom_range(0, 15)) ^ (($urandom_range(0, 1) == 1) ? 8'hF0 : 8'h00);
            do_op(w, op, a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
